seg7_scan_driver: RTL and testbench

- Time-multiplexed scan controller for the board's 8-digit common-anode 7-segment display.
- Holds a 32-bit display word (8 hex nibbles) and cycles through the digits one at a time.
- Per slot it drives the active-low anode strobe and decimal point, and presents the selected nibble on `nibble` to the downstream nibble-to-cathode decoder.
- New words are loaded through a strobe and applied only at frame boundaries, so a frame never mixes old and new digits.

---
 rtl/seg7_scan_driver.sv | 121 ++++++++++++
 tb/tb_seg7_scan_driver.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed scan controller for an up-to-8-digit common-anode
//   7-segment display. A 32-bit display word (8 hex nibbles) is shown one
//   digit per slot. New words are staged and committed only at the frame
//   boundary, so a frame never mixes digits from two different words.
//
// Ports
//   clk        in   system clock, all logic on the rising edge
//   reset      in   synchronous, active-high reset
//   value      in   [31:0] display word, nibble k = value[4k+3:4k], digit 0 rightmost
//   load       in   1-cycle strobe capturing value and dp_mask
//   dp_mask    in   [7:0] 1 = decimal point lit on that digit (captured with value)
//   digit_en   in   [7:0] live per-digit enable, 0 = anode off for that slot
//   nibble     out  [3:0] nibble of the digit currently scanned
//   anode_n    out  [7:0] active-low one-hot digit strobe
//   dp_n       out  active-low decimal point of the current digit
//   frame_done out  1-cycle pulse in the cycle after each completed frame
//
// Load handshake: load is a single-cycle strobe with no backpressure. Every
// load overwrites the staging registers (last write before the boundary wins)
// and marks them pending. At the boundary a load in that same cycle bypasses
// staging and goes straight to the shadow; otherwise pending staging data is
// committed. Either way pending clears on the boundary edge.
module seg7_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int NUM_DIGITS  = 8,
    parameter int LZ_BLANK    = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] value,
    input  logic        load,
    input  logic [7:0]  dp_mask,
    input  logic [7:0]  digit_en,
    output logic [3:0]  nibble,
    output logic [7:0]  anode_n,
    output logic        dp_n,
    output logic        frame_done
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [31:0]   r_shadow;
    logic [31:0]   r_staging;
    logic [7:0]    r_dp_shadow;
    logic [7:0]    r_dp_staging;
    logic          r_pending;
    logic          r_frame_done;

    logic          w_tick;
    logic          w_last_idx;
    logic          w_boundary;
    logic          w_tail_zero;
    logic          w_blank;
    logic          w_show;

    assign w_tick     = (r_cnt == CW'(REFRESH_DIV - 1));
    assign w_last_idx = (r_idx == 3'(NUM_DIGITS - 1));
    assign w_boundary = w_tick && w_last_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_shadow     <= '0;
            r_staging    <= '0;
            r_dp_shadow  <= '0;
            r_dp_staging <= '0;
            r_pending    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_cnt        <= w_tick ? '0 : r_cnt + CW'(1);
            r_frame_done <= w_boundary;

            if (w_tick) begin
                r_idx <= w_last_idx ? 3'd0 : r_idx + 3'd1;
            end

            if (load) begin
                r_staging    <= value;
                r_dp_staging <= dp_mask;
            end

            if (w_boundary) begin
                // Commit lands on the same edge idx wraps to 0.
                if (load) begin
                    r_shadow    <= value;
                    r_dp_shadow <= dp_mask;
                end else if (r_pending) begin
                    r_shadow    <= r_staging;
                    r_dp_shadow <= r_dp_staging;
                end
                r_pending <= 1'b0;
            end else if (load) begin
                r_pending <= 1'b1;
            end
        end
    end

    // True when every shadow nibble from the current index up to the top
    // scanned digit is zero, i.e. the current digit is a leading zero.
    always_comb begin
        w_tail_zero = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if ((k >= int'(r_idx)) && (k < NUM_DIGITS) && (r_shadow[4*k +: 4] != 4'h0)) begin
                w_tail_zero = 1'b0;
            end
        end
    end

    assign w_blank = (LZ_BLANK != 0) && (r_idx != 3'd0) && w_tail_zero;
    assign w_show  = digit_en[r_idx] && !w_blank;

    assign nibble     = r_shadow[{r_idx, 2'b00} +: 4];
    assign dp_n       = ~r_dp_shadow[r_idx];
    assign anode_n    = w_show ? ~(8'b0000_0001 << r_idx) : 8'hFF;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with REFRESH_DIV=4, NUM_DIGITS=8.
// Two instances share all inputs: u_dut (LZ_BLANK=0) and u_lz (LZ_BLANK=1).
// Time t counts falling edges after reset release; at t the DUT holds
// count t%4 and digit index (t/4)%8. Boundaries are at t%32==31.
module tb_seg7_scan_driver;

    logic        clk;
    logic        reset;
    logic [31:0] value;
    logic        load;
    logic [7:0]  dp_mask;
    logic [7:0]  digit_en;

    logic [3:0]  nibble0, nibble1;
    logic [7:0]  anode0, anode1;
    logic        dp0, dp1;
    logic        fd0, fd1;

    int t;
    int checks;
    int failures;

    logic [7:0] lz305_an [8];
    logic [3:0] lz305_nb [8];

    seg7_scan_driver #(.REFRESH_DIV(4), .NUM_DIGITS(8), .LZ_BLANK(0)) u_dut (
        .clk(clk), .reset(reset), .value(value), .load(load), .dp_mask(dp_mask),
        .digit_en(digit_en), .nibble(nibble0), .anode_n(anode0), .dp_n(dp0),
        .frame_done(fd0)
    );

    seg7_scan_driver #(.REFRESH_DIV(4), .NUM_DIGITS(8), .LZ_BLANK(1)) u_lz (
        .clk(clk), .reset(reset), .value(value), .load(load), .dp_mask(dp_mask),
        .digit_en(digit_en), .nibble(nibble1), .anode_n(anode1), .dp_n(dp1),
        .frame_done(fd1)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic step();
        @(negedge clk);
        t++;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
        end
    endtask

    function automatic int slot();
        return (t / 4) % 8;
    endfunction

    function automatic logic [7:0] onehot_n(input int i);
        logic [7:0] v;
        v = 8'hFF;
        v[i] = 1'b0;
        return v;
    endfunction

    function automatic logic [7:0] nib_of(input logic [31:0] w, input int i);
        logic [31:0] s;
        s = w >> (4 * i);
        return {4'h0, s[3:0]};
    endfunction

    function automatic logic [7:0] fd_exp();
        return {7'b0, (t > 0) && (t % 32 == 0)};
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        t        = 0;
        reset    = 1'b1;
        value    = '0;
        load     = 1'b0;
        dp_mask  = '0;
        digit_en = 8'hFF;
        lz305_an = '{8'hFE, 8'hFD, 8'hFB, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        lz305_nb = '{4'h5, 4'h0, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};

        step(); step(); step();

        // reset state
        chk("rst_nibble", {4'h0, nibble0}, 8'h00);
        chk("rst_anode",  anode0, 8'hFE);
        chk("rst_dp",     {7'b0, dp0}, 8'h01);
        chk("rst_fd",     {7'b0, fd0}, 8'h00);
        chk("rst_lz_anode", anode1, 8'hFE);
        reset = 1'b0;
        t = 0;

        // plain scan: FE x4, FD x4 ... 7F x4, FE again; frame_done at t=32
        while (t < 40) begin
            chk("scan_anode", anode0, onehot_n(slot()));
            chk("scan_fd", {7'b0, fd0}, fd_exp());
            chk("scan_lz_anode", anode1, (slot() == 0) ? 8'hFE : 8'hFF);
            step();
        end

        // load mid-frame twice; old (zero) word must persist until the wrap
        while (t < 64) begin
            chk("tear_nibble", {4'h0, nibble0}, 8'h00);
            load = 1'b0;
            if (t == 45) begin value = 32'h89ABCDEF; load = 1'b1; end
            if (t == 50) begin value = 32'h12345678; load = 1'b1; end
            step();
        end
        load = 1'b0;

        // only the second word is shown; a new load is staged at t=70
        while (t < 96) begin
            chk("last_wins_nibble", {4'h0, nibble0}, nib_of(32'h12345678, slot()));
            chk("last_wins_fd", {7'b0, fd0}, fd_exp());
            load = 1'b0;
            if (t == 70) begin value = 32'h89ABCDEF; load = 1'b1; end
            step();
        end
        load = 1'b0;

        // F,E,D,...,8; load in exactly the boundary cycle (t=127)
        while (t < 128) begin
            chk("seq_nibble", {4'h0, nibble0}, nib_of(32'h89ABCDEF, slot()));
            chk("seq_anode", anode0, onehot_n(slot()));
            load = 1'b0;
            if (t == 127) begin value = 32'h00000042; load = 1'b1; end
            step();
        end
        load = 1'b0;

        // bypass commit: idx 0 shows 2 right away, digit 1 shows 4
        while (t < 160) begin
            chk("bypass_nibble", {4'h0, nibble0}, nib_of(32'h00000042, slot()));
            chk("bypass_fd", {7'b0, fd0}, fd_exp());
            chk("bypass_dp", {7'b0, dp0}, 8'h01);
            load = 1'b0;
            if (t == 140) begin value = 32'h00000042; dp_mask = 8'h04; load = 1'b1; end
            step();
            if (t == 159) digit_en = 8'hFE;
        end
        load = 1'b0;

        // dp on digit 2 only; digit 0 disabled, slot timing unchanged
        while (t < 192) begin
            chk("mask_dp", {7'b0, dp0}, (slot() == 2) ? 8'h00 : 8'h01);
            chk("mask_anode", anode0, (slot() == 0) ? 8'hFF : onehot_n(slot()));
            chk("mask_nibble", {4'h0, nibble0}, nib_of(32'h00000042, slot()));
            step();
        end
        digit_en = 8'hFF;

        // stage 0x305 for the leading-zero checks
        while (t < 224) begin
            load = 1'b0;
            if (t == 192) begin value = 32'h00000305; dp_mask = 8'h00; load = 1'b1; end
            chk("pre_lz_nibble", {4'h0, nibble0}, nib_of(32'h00000042, slot()));
            step();
        end
        load = 1'b0;

        // 0x305: LZ instance lights slots 0..2 only; plain instance all
        while (t < 256) begin
            chk("lz305_anode", anode1, lz305_an[slot()]);
            chk("lz305_nibble", {4'h0, nibble1}, {4'h0, lz305_nb[slot()]});
            chk("nolz305_anode", anode0, onehot_n(slot()));
            load = 1'b0;
            if (t == 230) begin value = 32'h00000000; load = 1'b1; end
            step();
        end
        load = 1'b0;

        // value 0: LZ instance lights slot 0 only
        while (t < 288) begin
            chk("lz0_anode", anode1, (slot() == 0) ? 8'hFE : 8'hFF);
            chk("lz0_nibble", {4'h0, nibble1}, 8'h00);
            chk("nolz0_anode", anode0, onehot_n(slot()));
            step();
        end

        // load then reset before the boundary: staged data is discarded
        while (t < 295) begin
            load = 1'b0;
            if (t == 290) begin value = 32'h0000ABCD; dp_mask = 8'hFF; load = 1'b1; end
            if (t == 294) reset = 1'b1;
            step();
        end
        load = 1'b0;
        step();
        chk("rst2_nibble", {4'h0, nibble0}, 8'h00);
        chk("rst2_anode",  anode0, 8'hFE);
        chk("rst2_dp",     {7'b0, dp0}, 8'h01);
        reset = 1'b0;
        t = 0;
        while (t < 44) begin
            chk("post_rst_nibble", {4'h0, nibble0}, 8'h00);
            chk("post_rst_dp", {7'b0, dp0}, 8'h01);
            chk("post_rst_anode", anode0, onehot_n(slot()));
            chk("post_rst_fd", {7'b0, fd0}, fd_exp());
            step();
        end

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
